// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and line geometry for mem_arbiter.
package mem_arb_pkg;
    localparam int BURST_WORDS = 8;
    localparam int WORD_BYTES = 2;
    localparam int CNT_W = $clog2(BURST_WORDS);
    localparam logic [15:0] LINE_MASK = 16'hFFF0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IC = 2'd1, OWN_DC = 2'd2} owner_e;
    function automatic logic [15:0] beat_addr(input logic [15:0] base, input logic [CNT_W-1:0] idx);
        return base + 16'(idx) * 16'(WORD_BYTES);
    endfunction
endpackage

// File: rtl/arb_beat_counter.sv
// arb_beat_counter: wrapping beat counter with clear and terminal-count flag.
module arb_beat_counter #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end
    assign o_cnt = r_cnt;
    assign o_last = &r_cnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for I-fill, D-fill and D write-through.
// Define ARB_RR_EN for round-robin I/D fill tie-break; default is fixed D over I.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ic_req,
    input  logic [15:0] i_ic_addr,
    input  logic        i_dc_req,
    input  logic [15:0] i_dc_addr,
    input  logic        i_wr_req,
    input  logic [15:0] i_wr_addr,
    input  logic [15:0] i_wr_data,
    output logic        o_mem_enable,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_data_valid,
    output logic        o_ic_data_valid,
    output logic        o_dc_data_valid,
    output logic [15:0] o_fill_data,
    output logic [15:0] o_fill_addr,
    output logic        o_ic_done,
    output logic        o_dc_done,
    output logic        o_wr_ack
);
    logic [1:0]       r_state;
    owner_e           r_owner;
    logic [15:0]      r_base;
    logic [CNT_W-1:0] w_issue_cnt;
    logic [CNT_W-1:0] w_ret_cnt;
    logic             w_issue_last;
    logic             w_ret_last;
    logic             w_pick_dc;
    logic             w_grant_fill;
    logic             w_beat;
    logic             w_done;

`ifdef ARB_RR_EN
    owner_e r_last_fill;
    // The fill served most recently loses a simultaneous I/D tie.
    assign w_pick_dc = i_dc_req && (!i_ic_req || r_last_fill != OWN_DC);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_last_fill <= OWN_NONE;
        else if (w_done) r_last_fill <= r_owner;
    end
`else
    assign w_pick_dc = i_dc_req;
`endif

    assign w_grant_fill = r_state == ST_IDLE && !i_wr_req && (i_dc_req || i_ic_req);
    // Beats outside a fill (stale after reset, or spurious) are dropped.
    assign w_beat = i_mem_data_valid && (r_state == ST_ISSUE || r_state == ST_DRAIN);
    assign w_done = w_beat && w_ret_last;

    arb_beat_counter #(.W(CNT_W)) u_issue (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_grant_fill), .i_en(r_state == ST_ISSUE),
        .o_cnt(w_issue_cnt), .o_last(w_issue_last)
    );
    arb_beat_counter #(.W(CNT_W)) u_ret (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_grant_fill), .i_en(w_beat),
        .o_cnt(w_ret_cnt), .o_last(w_ret_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_base <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_wr_req) r_state <= ST_WRITE;
                    else if (w_grant_fill) begin
                        r_state <= ST_ISSUE;
                        r_owner <= w_pick_dc ? OWN_DC : OWN_IC;
                        r_base <= (w_pick_dc ? i_dc_addr : i_ic_addr) & LINE_MASK;
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_ISSUE: r_state <= w_done ? ST_IDLE : w_issue_last ? ST_DRAIN : ST_ISSUE;
                default:  r_state <= w_done ? ST_IDLE : ST_DRAIN;
            endcase
            if (w_done) r_owner <= OWN_NONE;
        end
    end

    assign o_mem_enable = r_state == ST_WRITE || r_state == ST_ISSUE;
    assign o_mem_wr = r_state == ST_WRITE;
    assign o_mem_addr = r_state == ST_WRITE ? i_wr_addr :
                        r_state == ST_ISSUE ? beat_addr(r_base, w_issue_cnt) : 16'h0;
    assign o_mem_wdata = r_state == ST_WRITE ? i_wr_data : 16'h0;
    assign o_wr_ack = r_state == ST_WRITE;
    assign o_ic_data_valid = w_beat && r_owner == OWN_IC;
    assign o_dc_data_valid = w_beat && r_owner == OWN_DC;
    assign o_fill_data = i_mem_rdata;
    assign o_fill_addr = w_beat ? beat_addr(r_base, w_ret_cnt) : 16'h0;
    assign o_ic_done = w_done && r_owner == OWN_IC;
    assign o_dc_done = w_done && r_owner == OWN_DC;
endmodule
